// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x-style oversampling.
// Recovers bytes from rx and flags frames whose stop bit is low.
module uart_rx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TMAX  = TW'(DIV - 1);
  localparam logic [SW-1:0] SHALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic          fall;
  logic          tick;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;
  assign tick = (tcnt == TMAX);

  // Tick divider; held at zero in IDLE so phase aligns to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Frame FSM with registered strobes and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            scnt    <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (scnt == SHALF) begin
              scnt <= '0;
              bidx <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (scnt == SLAST) begin
              scnt  <= '0;
              shreg <= {rx_s, shreg[7:1]};
              bidx  <= bidx + 3'd1;
              if (bidx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (scnt == SLAST) begin
              scnt    <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx.
// Fast instance (DIV=1) plus a default-rate instance.
module tb_uart_rx;

  localparam int BT_A = 16;
  localparam int BT_B = 432;

  logic       clk;
  logic       rst;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] rx_data_a;
  logic       rx_valid_a;
  logic       rx_busy_a;
  logic       frame_err_a;
  logic [7:0] rx_data_b;
  logic       rx_valid_b;
  logic       rx_busy_b;
  logic       frame_err_b;

  int checks;
  int errors;
  int cyc;

  logic [7:0] vq_a[$];
  logic [7:0] vq_b[$];
  int         vcyc_b[$];
  int         ferr_a;
  int         ferr_b;
  int         both_cnt;
  int         wide_cnt;
  int         bad_busy;
  logic       prev_va;

  uart_rx #(
    .CLOCK_FREQ(1600000),
    .BAUD_RATE (100000),
    .OVERSAMPLE(16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_a),
    .rx_data  (rx_data_a),
    .rx_valid (rx_valid_a),
    .rx_busy  (rx_busy_a),
    .frame_err(frame_err_a)
  );

  uart_rx u_def (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_b),
    .rx_data  (rx_data_b),
    .rx_valid (rx_valid_b),
    .rx_busy  (rx_busy_b),
    .frame_err(frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid_a) vq_a.push_back(rx_data_a);
    if (frame_err_a) ferr_a <= ferr_a + 1;
    if (rx_valid_a && frame_err_a) both_cnt <= both_cnt + 1;
    if (rx_valid_b && frame_err_b) both_cnt <= both_cnt + 1;
    if (rx_valid_a && prev_va) wide_cnt <= wide_cnt + 1;
    if (rx_valid_a && rx_busy_a) bad_busy <= bad_busy + 1;
    prev_va <= rx_valid_a;
    if (rx_valid_b) begin
      vq_b.push_back(rx_data_b);
      vcyc_b.push_back(cyc);
    end
    if (frame_err_b) ferr_b <= ferr_b + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send_byte(input bit sel,
                           input logic [7:0] b,
                           input logic stopbit);
    int bt;
    bt = sel ? BT_B : BT_A;
    @(negedge clk);
    set_rx(sel, 1'b0);
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, b[i]);
      repeat (bt) @(negedge clk);
    end
    set_rx(sel, stopbit);
    repeat (bt) @(negedge clk);
    set_rx(sel, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         base;
  int         fbase;
  int         fall1;
  int         fall2;
  int         d;
  logic [7:0] c3;

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    ferr_a   = 0;
    ferr_b   = 0;
    both_cnt = 0;
    wide_cnt = 0;
    bad_busy = 0;
    prev_va  = 1'b0;
    rst      = 1'b1;
    rx_a     = 1'b1;
    rx_b     = 1'b1;
    idle(4);
    check("rst_data", {24'd0, rx_data_a}, 32'h00);
    check("rst_valid", {31'd0, rx_valid_a}, 32'd0);
    check("rst_busy", {31'd0, rx_busy_a}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_a}, 32'd0);
    rst = 1'b0;
    idle(4);

    // Test 1: single byte
    base = vq_a.size();
    fork
      send_byte(1'b0, 8'hA5, 1'b1);
      begin
        idle(40);
        check("t1_busy_mid", {31'd0, rx_busy_a}, 32'd1);
      end
    join
    idle(BT_A);
    check("t1_count", vq_a.size() - base, 32'd1);
    if (vq_a.size() > base) check("t1_data", {24'd0, vq_a[base]}, 32'hA5);
    check("t1_width", wide_cnt, 32'd0);
    check("t1_busy_at_valid", bad_busy, 32'd0);
    check("t1_busy_end", {31'd0, rx_busy_a}, 32'd0);

    // Test 2: back-to-back
    base  = vq_a.size();
    fbase = ferr_a;
    send_byte(1'b0, 8'h00, 1'b1);
    send_byte(1'b0, 8'hFF, 1'b1);
    send_byte(1'b0, 8'h55, 1'b1);
    idle(BT_A);
    check("t2_count", vq_a.size() - base, 32'd3);
    if (vq_a.size() >= base + 3) begin
      check("t2_b0", {24'd0, vq_a[base]}, 32'h00);
      check("t2_b1", {24'd0, vq_a[base+1]}, 32'hFF);
      check("t2_b2", {24'd0, vq_a[base+2]}, 32'h55);
    end
    check("t2_ferr", ferr_a - fbase, 32'd0);

    // Test 3: glitch
    base  = vq_a.size();
    fbase = ferr_a;
    rx_a  = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(30);
    check("t3_busy", {31'd0, rx_busy_a}, 32'd0);
    check("t3_valid", vq_a.size() - base, 32'd0);
    check("t3_ferr", ferr_a - fbase, 32'd0);

    // Test 4: framing error then good frame
    base  = vq_a.size();
    fbase = ferr_a;
    send_byte(1'b0, 8'h3C, 1'b0);
    idle(2 * BT_A);
    check("t4_ferr", ferr_a - fbase, 32'd1);
    check("t4_hold", {24'd0, rx_data_a}, 32'h55);
    check("t4_novalid", vq_a.size() - base, 32'd0);
    send_byte(1'b0, 8'h81, 1'b1);
    idle(BT_A);
    check("t4_count", vq_a.size() - base, 32'd1);
    if (vq_a.size() > base) check("t4_data", {24'd0, vq_a[base]}, 32'h81);
    check("t4_ferr_once", ferr_a - fbase, 32'd1);

    // Test 5: reset during data bit 4 of 8'hC3
    base  = vq_a.size();
    fbase = ferr_a;
    c3    = 8'hC3;
    rx_a  = 1'b0;
    idle(BT_A);
    for (int i = 0; i < 4; i++) begin
      rx_a = c3[i];
      idle(BT_A);
    end
    rx_a = c3[4];
    idle(BT_A / 2);
    rst = 1'b1;
    idle(2);
    check("t5_rst_data", {24'd0, rx_data_a}, 32'h00);
    check("t5_rst_valid", {31'd0, rx_valid_a}, 32'd0);
    check("t5_rst_busy", {31'd0, rx_busy_a}, 32'd0);
    check("t5_rst_ferr", {31'd0, frame_err_a}, 32'd0);
    rx_a = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(4 * BT_A);
    check("t5_abort", vq_a.size() - base, 32'd0);
    send_byte(1'b0, 8'h12, 1'b1);
    idle(BT_A);
    check("t5_count", vq_a.size() - base, 32'd1);
    if (vq_a.size() > base) check("t5_data", {24'd0, vq_a[base]}, 32'h12);
    check("t5_ferr", ferr_a - fbase, 32'd0);

    // Test 6: default rate, DIV=27
    base = vq_b.size();
    send_byte(1'b1, 8'h4B, 1'b1);
    fall1 = cyc;
    send_byte(1'b1, 8'hE7, 1'b1);
    fall2 = cyc;
    idle(BT_B);
    check("t6_count", vq_b.size() - base, 32'd2);
    if (vq_b.size() >= base + 2) begin
      check("t6_b0", {24'd0, vq_b[base]}, 32'h4B);
      check("t6_b1", {24'd0, vq_b[base+1]}, 32'hE7);
      d = vcyc_b[base] - fall1;
      if (d < 0) d = -d;
      check("t6_lat0", (d <= BT_B) ? 32'd1 : 32'd0, 32'd1);
      d = vcyc_b[base+1] - fall2;
      if (d < 0) d = -d;
      check("t6_lat1", (d <= BT_B) ? 32'd1 : 32'd0, 32'd1);
    end
    check("t6_ferr", ferr_b, 32'd0);
    check("excl", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the downstream counterpart of the transmitter on the UART link. It samples the serial `rx` line with a 16x oversampling tick derived from the system clock and recovers 8N1 frames (start 0, 8 data bits LSB first, stop 1). Each recovered byte is presented on a parallel bus with a one-cycle valid strobe. Frames with a bad stop bit are flagged instead of delivered.

## Interface
- `CLOCK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line bit rate in baud.
- `OVERSAMPLE`, default 16: sample ticks per bit. It must be even and at least 4.

- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `rx`, input, 1: serial line. It is asynchronous to `clk` and idles high.
- `rx_data`, output, 8: last correctly received byte. It is held until the next good frame.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` has just been updated.
- `rx_busy`, output, 1: high while a frame is in progress (any state other than IDLE).
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchronizer:** two-flop synchronizer on `rx`, giving `rx_s`. Both flops reset to 1. Edge detection uses `rx_s` and a third, delayed flop (also reset to 1).
- **Tick generator:**
  - `DIV = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE)`, integer floor, minimum 1.
  - Counter runs 0..DIV-1. `tick` is high in the cycle where count == DIV-1.
  - The counter is cleared to 0 on the falling-edge detect in IDLE, so sampling phase is aligned to the start edge.
- **States:** IDLE, START, DATA, STOP.
  - IDLE: wait for a falling edge on `rx_s`, then go to START and clear the tick counter and the sample counter.
  - START: on the tick where the sample count reaches OVERSAMPLE/2 - 1 (mid start bit):
    - if `rx_s` == 0, go to DATA with bit index 0 and sample count 0;
    - otherwise it is a glitch: return to IDLE with no output.
  - DATA: every OVERSAMPLE ticks, sample `rx_s` into a shift register, LSB first (bit i lands in `rx_data[i]`). After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample `rx_s`:
    - if 1, load the shift register into `rx_data` and pulse `rx_valid`;
    - if 0, pulse `frame_err` and leave `rx_data` unchanged.
    - Either way, return to IDLE.
- **Line stuck low after a framing error:** no new start is accepted until `rx_s` has returned high and then fallen again. The falling-edge requirement enforces this.
- **Counter widths:** the sample counter is wide enough for OVERSAMPLE-1, the bit index is 3 bits, and the tick counter is wide enough for DIV-1. None of these counters wraps outside its state.
- **No backpressure:** the consumer must take the byte on the `rx_valid` cycle. An unread byte is overwritten by the next good frame.

## Timing
- **Reset values:**
  - `rx_data` = 8'h00, `rx_valid` = 0, `rx_busy` = 0, `frame_err` = 0;
  - state = IDLE, all counters 0.
- **Reset mid-frame:** returns immediately to IDLE. The partial byte is discarded and no pulse is emitted.
- **Input latency:** 2 cycles from `rx` pin to `rx_s`, plus 1 cycle for edge detect.
- **Sample points,** counted in ticks after the start detect:
  - start bit check at OVERSAMPLE/2;
  - data bit i at OVERSAMPLE/2 + OVERSAMPLE*(i+1);
  - stop bit at OVERSAMPLE/2 + 9*OVERSAMPLE, which is 152 ticks at the default.
- **Output timing:**
  - `rx_valid` or `frame_err` rises in the cycle after the stop sample and is high for exactly 1 cycle.
  - `rx_busy` falls in that same cycle.
- **Back-to-back frames:** the next start edge may arrive immediately after the mid-stop sample. IDLE is re-entered before the end of the stop bit, so consecutive frames with no idle gap must be received.
- **Output exclusivity:** `rx_valid` and `frame_err` are never high together.

## Test plan
Tests 1–4 use CLOCK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, which gives DIV=1 and a 16-cycle bit.

1. **Single byte:** drive 8'hA5 as 8N1, 16 cycles per bit, from reset.
   - `rx_valid` pulses once, exactly 1 cycle wide, with `rx_data`=8'hA5.
   - `rx_busy` is high from the start detect until the pulse.
2. **Back-to-back:** send 8'h00, 8'hFF and 8'h55 with no idle gap.
   - Three `rx_valid` pulses with those values, in that order.
   - `frame_err` never asserts.
3. **Glitch:** drive `rx` low for 4 cycles, then high.
   - No state change past START.
   - `rx_busy` returns low, and no `rx_valid` or `frame_err` pulse occurs.
4. **Framing error:** send 8'h3C with the stop bit driven 0, then idle high, then send 8'h81.
   - `frame_err` pulses once and `rx_data` stays at its prior value.
   - The following 8'h81 is received correctly.
5. **Reset mid-frame:** assert `rst` during data bit 4 of 8'hC3, release it, then send 8'h12.
   - Outputs are at their reset values during reset.
   - No pulse is emitted for the aborted frame; 8'h12 is received with one `rx_valid`.
6. **Loopback at defaults:** connect the transmitter's `tx` to `rx` at 50 MHz / 115200 and send 8'h4B and 8'hE7 (DIV=27).
   - Both bytes are received in order.
   - Each `rx_valid` occurs within 1 bit period after the transmitter's `tx_busy` falls.
